sipo_rx: RTL and testbench

- Serial-in parallel-out receiver; the receive-side counterpart of the team's 16-bit parallel-in serial-out shifter.
- Collects WIDTH serial bits, MSB first, framed by a start-of-frame strobe.
- Presents each completed word on a valid/ready parallel output with a one-word holding register, so reception continues while the consumer stalls.
- Sits at the far end of the serial link and feeds downstream parallel logic.

---
 rtl/sipo_pkg.sv | 25 ++
 rtl/sipo_rx_if.sv | 28 ++
 rtl/sipo_hold_buf.sv | 55 +++++
 rtl/sipo_rx.sv | 101 ++++++++++
 tb/tb_sipo_rx.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sipo_pkg.sv
// Shared types and sizing helpers for the sipo_rx serial receiver.
// SIPO_RX_PARITY_EN adds one even-parity bit to every frame.
package sipo_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam int SIPO_DEFAULT_WIDTH = 16;

    // Bits on the wire per frame: data bits, plus the trailing parity bit when enabled.
    function automatic int frame_len(input int width);
`ifdef SIPO_RX_PARITY_EN
        return width + 1;
`else
        return width;
`endif
    endfunction

    function automatic int cnt_width(input int width);
        return $clog2(width + 2);
    endfunction

endpackage

// File: rtl/sipo_rx_if.sv
// Serial input and parallel valid/ready output bundle of the sipo_rx receiver.
interface sipo_rx_if
    import sipo_pkg::*;
#(
    parameter int WIDTH = SIPO_DEFAULT_WIDTH
);
    logic             SIN;
    logic             SIN_EN;
    logic             SOF;
    logic [WIDTH-1:0] DOUT;
    logic             DOUT_VALID;
    logic             DOUT_READY;
    logic             BUSY;
    logic             OVERRUN;
    logic             FRAME_ERR;
    logic             PARITY_ERR;

    // master: the serial source plus the parallel consumer
    modport master (
        output SIN, SIN_EN, SOF, DOUT_READY,
        input  DOUT, DOUT_VALID, BUSY, OVERRUN, FRAME_ERR, PARITY_ERR
    );

    modport slave (
        input  SIN, SIN_EN, SOF, DOUT_READY,
        output DOUT, DOUT_VALID, BUSY, OVERRUN, FRAME_ERR, PARITY_ERR
    );
endinterface

// File: rtl/sipo_hold_buf.sv
// One-word valid/ready holding register; a word arriving while the held one
// is stalled is dropped and reported on overrun.
module sipo_hold_buf
    import sipo_pkg::*;
#(
    parameter int DW = SIPO_DEFAULT_WIDTH + 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    output logic          overrun
);

    logic [DW-1:0] data_q, data_d;
    logic          valid_q, valid_d;
    logic          overrun_q, overrun_d;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        if (in_valid) begin
            // The slot is free if empty or being drained on this very edge.
            if (!valid_q || out_ready) begin
                data_d  = in_data;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign overrun   = overrun_q;

endmodule

// File: rtl/sipo_rx.sv
// Serial-in parallel-out receiver: MSB-first frames opened by SOF, handed to a
// one-word holding buffer. Define SIPO_RX_PARITY_EN for a trailing even-parity bit.
module sipo_rx
    import sipo_pkg::*;
#(
    parameter int WIDTH = SIPO_DEFAULT_WIDTH
) (
    input  logic     CLK,
    input  logic     RST,
    sipo_rx_if.slave bus
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] FLEN_C = CW'(frame_len(WIDTH));
`ifdef SIPO_RX_PARITY_EN
    localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);
`endif

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             frame_err_q, frame_err_d;

    logic             word_done;
    logic [WIDTH-1:0] word_data;
    logic             word_perr;
    logic [WIDTH:0]   hold_data;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            cnt_q       <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        frame_err_d = 1'b0;
        word_done   = 1'b0;
`ifdef SIPO_RX_PARITY_EN
        word_data   = shreg_q;
        word_perr   = (^shreg_q) ^ bus.SIN;
`else
        word_data   = {shreg_q[WIDTH-2:0], bus.SIN};
        word_perr   = 1'b0;
`endif
        if (bus.SIN_EN) begin
            if (bus.SOF) begin
                // The first bit lands at the LSB and reaches the MSB after WIDTH-1 shifts.
                frame_err_d = (state_q == SHIFT);
                state_d     = SHIFT;
                shreg_d     = {{(WIDTH-1){1'b0}}, bus.SIN};
                cnt_d       = CW'(1);
            end else if (state_q == SHIFT) begin
                cnt_d = cnt_q + CW'(1);
`ifdef SIPO_RX_PARITY_EN
                if (cnt_q < WIDTH_C) begin
                    shreg_d = {shreg_q[WIDTH-2:0], bus.SIN};
                end
`else
                shreg_d = {shreg_q[WIDTH-2:0], bus.SIN};
`endif
                if (cnt_q + CW'(1) == FLEN_C) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    word_done = 1'b1;
                end
            end
        end
    end

    always_comb begin
        bus.BUSY       = (state_q == SHIFT);
        bus.FRAME_ERR  = frame_err_q;
        bus.DOUT       = hold_data[WIDTH-1:0];
        bus.PARITY_ERR = hold_data[WIDTH];
    end

    sipo_hold_buf #(
        .DW(WIDTH + 1)
    ) u_hold (
        .CLK       (CLK),
        .RST       (RST),
        .in_valid  (word_done),
        .in_data   ({word_perr, word_data}),
        .out_ready (bus.DOUT_READY),
        .out_data  (hold_data),
        .out_valid (bus.DOUT_VALID),
        .overrun   (bus.OVERRUN)
    );

endmodule

// File: tb/tb_sipo_rx.sv
// Self-checking bench for sipo_rx: frame table plus hand-written corner sequences,
// delivered words checked against a scoreboard queue.
module tb_sipo_rx;

`ifdef SIPO_RX_PARITY_EN
    localparam int FL = 17;
`else
    localparam int FL = 16;
`endif

    typedef struct {
        logic [15:0] dout;
        logic        perr;
    } exp_t;

    typedef struct {
        logic [15:0] data;
        int          en_pct;
        logic [15:0] exp_dout;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sipo_rx_if #(.WIDTH(16)) bus ();

    sipo_rx #(.WIDTH(16)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   busy_cnt = 0;
    int   valid_cnt = 0;
    int   ovr_cnt = 0;
    int   ferr_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Monitor: a word is consumed on the edge following a negedge with VALID & READY.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.BUSY)       busy_cnt++;
            if (bus.DOUT_VALID) valid_cnt++;
            if (bus.OVERRUN)    ovr_cnt++;
            if (bus.FRAME_ERR)  ferr_cnt++;
            if (bus.DOUT_VALID && bus.DOUT_READY) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got word %h expected none", bus.DOUT);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sb_dout", 32'(bus.DOUT), 32'(e.dout));
                    check("sb_perr", 32'(bus.PARITY_ERR), 32'(e.perr));
                end
            end
        end
    end

    task automatic idle_cycle();
        bus.SIN_EN = 1'b0;
        bus.SOF    = 1'b0;
        bus.SIN    = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic s, input logic sof);
        bus.SIN_EN = 1'b1;
        bus.SIN    = s;
        bus.SOF    = sof;
        @(posedge clk);
        #1;
        bus.SIN_EN = 1'b0;
        bus.SOF    = 1'b0;
        bus.SIN    = 1'($urandom_range(0, 1));
    endtask

    // Returns right after the edge that samples the last frame bit.
    task automatic send_frame(input logic [15:0] w, input int pct, input bit push,
                              input bit rdy_last, input bit bad_par);
        logic [16:0] bits;
        exp_t        e;
`ifdef SIPO_RX_PARITY_EN
        bits   = {w, (^w) ^ bad_par};
        e.perr = bad_par;
`else
        bits   = {1'b0, w};
        e.perr = 1'b0;
`endif
        e.dout = w;
        if (push) sb.push_back(e);
        for (int k = FL - 1; k >= 0; k--) begin
            int g = 0;
            while (g < 8 && int'($urandom_range(0, 99)) >= pct) begin
                idle_cycle();
                g++;
            end
            if (k == 0 && rdy_last) bus.DOUT_READY = 1'b1;
            strobe(bits[k], (k == FL - 1));
        end
    endtask

    vec_t vecs[6];

    initial begin
        logic [15:0] w;
        int b0, v0, o0, f0;

        vecs[0] = '{16'hA5C3, 100, 16'hA5C3};
        vecs[1] = '{16'hA5C3,  50, 16'hA5C3};
        vecs[2] = '{16'h0000, 100, 16'h0000};
        vecs[3] = '{16'hFFFF,  70, 16'hFFFF};
        vecs[4] = '{16'h8001, 100, 16'h8001};
        vecs[5] = '{16'h1234,  30, 16'h1234};

        bus.SIN = 1'b0; bus.SIN_EN = 1'b0; bus.SOF = 1'b0; bus.DOUT_READY = 1'b1;
        #1 rst = 1'b1;
        #1;
        check("rst_dout",  32'(bus.DOUT), 32'h0);
        check("rst_valid", 32'(bus.DOUT_VALID), 32'h0);
        check("rst_busy",  32'(bus.BUSY), 32'h0);
        check("rst_flags", 32'({bus.OVERRUN, bus.FRAME_ERR, bus.PARITY_ERR}), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // Single continuous frame: SHIFT spans from the SOF edge to the last-bit edge.
        b0 = busy_cnt; v0 = valid_cnt;
        sb.push_back('{16'hA5C3, 1'b0});
        w = 16'hA5C3;
        strobe(w[15], 1'b1);
        check("single_busy_rise", 32'(bus.BUSY), 32'h1);
        for (int k = 14; k >= 0; k--) strobe(w[k], 1'b0);
`ifdef SIPO_RX_PARITY_EN
        strobe(^w, 1'b0);
`endif
        check("single_valid_lat", 32'(bus.DOUT_VALID), 32'h1);
        check("single_dout_lat",  32'(bus.DOUT), 32'hA5C3);
        check("single_busy_fall", 32'(bus.BUSY), 32'h0);
        repeat (3) idle_cycle();
        check("single_busy_cycles", 32'(busy_cnt - b0), 32'(FL - 1));
        check("single_valid_cycles", 32'(valid_cnt - v0), 32'h1);

        // Table-driven frames, some with gapped strobes.
        for (int i = 0; i < 6; i++) begin
            v0 = valid_cnt;
            sb.push_back('{vecs[i].exp_dout, 1'b0});
            send_frame(vecs[i].data, vecs[i].en_pct, 1'b0, 1'b0, 1'b0);
            check("vec_dout", 32'(bus.DOUT), 32'(vecs[i].exp_dout));
            repeat (2) idle_cycle();
            check("vec_valid_once", 32'(valid_cnt - v0), 32'h1);
            check("vec_drained", 32'(sb.size()), 32'h0);
        end

        // Back-to-back frames with no gap between last bit and next SOF.
        send_frame(16'h5A5A, 100, 1'b1, 1'b0, 1'b0);
        send_frame(16'h0F0F, 100, 1'b1, 1'b0, 1'b0);
        check("b2b_dout", 32'(bus.DOUT), 32'h0F0F);
        repeat (3) idle_cycle();
        check("b2b_drained", 32'(sb.size()), 32'h0);

        // Backpressure and overrun.
        bus.DOUT_READY = 1'b0;
        o0 = ovr_cnt;
        send_frame(16'h1234, 100, 1'b1, 1'b0, 1'b0);
        repeat (2) idle_cycle();
        send_frame(16'hFFFF, 100, 1'b0, 1'b0, 1'b0);
        repeat (3) idle_cycle();
        check("bp_hold_dout", 32'(bus.DOUT), 32'h1234);
        check("bp_hold_valid", 32'(bus.DOUT_VALID), 32'h1);
        check("bp_overrun_once", 32'(ovr_cnt - o0), 32'h1);
        send_frame(16'h00FF, 100, 1'b1, 1'b1, 1'b0);
        check("bp_same_edge_dout", 32'(bus.DOUT), 32'h00FF);
        check("bp_same_edge_valid", 32'(bus.DOUT_VALID), 32'h1);
        repeat (3) idle_cycle();
        check("bp_no_new_overrun", 32'(ovr_cnt - o0), 32'h1);
        check("bp_drained", 32'(sb.size()), 32'h0);

        // Mid-frame SOF, then stray strobes in IDLE.
        f0 = ferr_cnt;
        w = 16'h6D2B;
        strobe(w[15], 1'b1);
        for (int k = 14; k >= 11; k--) strobe(w[k], 1'b0);
        send_frame(16'h8001, 100, 1'b1, 1'b0, 1'b0);
        check("sof_dout", 32'(bus.DOUT), 32'h8001);
        repeat (2) idle_cycle();
        check("sof_ferr_once", 32'(ferr_cnt - f0), 32'h1);
        v0 = valid_cnt;
        for (int k = 0; k < 6; k++) strobe(1'(k), 1'b0);
        repeat (2) idle_cycle();
        check("idle_ignored_busy", 32'(bus.BUSY), 32'h0);
        check("idle_ignored_valid", 32'(valid_cnt - v0), 32'h0);
        check("idle_ignored_ferr", 32'(ferr_cnt - f0), 32'h1);

        // Parity: 0x0007 has odd data parity, so a parity bit of 1 is correct.
        send_frame(16'h0007, 100, 1'b1, 1'b0, 1'b0);
        repeat (2) idle_cycle();
        send_frame(16'h0007, 100, 1'b1, 1'b0, 1'b1);
        check("par_dout", 32'(bus.DOUT), 32'h0007);
        repeat (3) idle_cycle();

        // Reset mid-frame, over a stalled held word.
        bus.DOUT_READY = 1'b0;
        send_frame(16'h1234, 100, 1'b0, 1'b0, 1'b0);
        idle_cycle();
        w = 16'hA5C3;
        strobe(w[15], 1'b1);
        for (int k = 14; k >= 9; k--) strobe(w[k], 1'b0);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_dout",  32'(bus.DOUT), 32'h0);
        check("mid_rst_valid", 32'(bus.DOUT_VALID), 32'h0);
        check("mid_rst_busy",  32'(bus.BUSY), 32'h0);
        check("mid_rst_flags", 32'({bus.OVERRUN, bus.FRAME_ERR, bus.PARITY_ERR}), 32'h0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        bus.DOUT_READY = 1'b1;
        send_frame(16'hA5C3, 100, 1'b1, 1'b0, 1'b0);
        check("post_rst_dout", 32'(bus.DOUT), 32'hA5C3);
        repeat (3) idle_cycle();
        check("final_drained", 32'(sb.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
